// File: rtl/cr_huf_comp_sa_lut_rdr.sv
// Read client of the Huffman LUT ping-pong pair: waits for the bank table, issues up to four
// lane reads per beat and returns code words in request order through a credit-managed skid FIFO.
module cr_huf_comp_sa_lut_rdr #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 27,
    parameter int SEQID_W = 2,
    parameter int RD_LAT  = 2,
    parameter int FIFO_D  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  job_val,
    output logic                  job_rdy,
    input  logic [SEQID_W-1:0]    job_seq_id,
    input  logic                  sym_val,
    output logic                  sym_rdy,
    input  logic [4*ADDR_W-1:0]   sym_addr,
    input  logic [2:0]            sym_cnt,
    input  logic                  sym_last,
    output logic                  sa_lut_data_rd,
    output logic [ADDR_W-1:0]     sa_lut_data_addr0,
    output logic [ADDR_W-1:0]     sa_lut_data_addr1,
    output logic [ADDR_W-1:0]     sa_lut_data_addr2,
    output logic [ADDR_W-1:0]     sa_lut_data_addr3,
    output logic [SEQID_W-1:0]    sa_lut_seq_id,
    output logic                  sa_lut_ret_ack,
    input  logic                  lut_sa_hw_vld,
    input  logic                  lut_sa_data_val,
    input  logic [DATA_W-1:0]     lut_sa_rd_data0,
    input  logic [DATA_W-1:0]     lut_sa_rd_data1,
    input  logic [DATA_W-1:0]     lut_sa_rd_data2,
    input  logic [DATA_W-1:0]     lut_sa_rd_data3,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [4*DATA_W-1:0]   out_data,
    output logic [2:0]            out_cnt,
    output logic                  out_last,
    output logic                  rdr_err
);

    localparam int CNT_W = $clog2(FIFO_D + 1);
    localparam int SB_D  = FIFO_D + RD_LAT;
    localparam int DP_W  = $clog2(FIFO_D);
    localparam int SP_W  = $clog2(SB_D);
    localparam logic [DP_W-1:0]  DP_LAST = DP_W'(FIFO_D - 1);
    localparam logic [SP_W-1:0]  SP_LAST = SP_W'(SB_D - 1);
    localparam logic [CNT_W:0]   CREDITS = (CNT_W + 1)'(FIFO_D);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TBL,
        ST_STREAM,
        ST_DRAIN,
        ST_ACK
    } state_t;

    state_t              state_q;
    logic [SEQID_W-1:0]  seq_q;
    logic [CNT_W-1:0]    outst_q, outst_d;
    logic [CNT_W-1:0]    dcnt_q, dcnt_d;
    logic [DP_W-1:0]     dwr_q, drd_q;
    logic [SP_W-1:0]     swr_q, srd_q;
    logic                err_q;

    logic [4*DATA_W-1:0] dmem [FIFO_D];
    logic [3:0]          smem [SB_D];

    logic [2:0]          cnt_eff;
    logic                sym_hs;
    logic                rsp_push;
    logic                out_pop;
    logic [CNT_W:0]      credit_used;
    logic [3:0]          sb_head;
    logic [4*DATA_W-1:0] d_head;

    assign cnt_eff        = (sym_cnt == 3'd0 || sym_cnt > 3'd4) ? 3'd4 : sym_cnt;
    // In-flight reads hold a credit so a response always finds room in the data FIFO.
    assign credit_used    = {1'b0, outst_q} + {1'b0, dcnt_q};
    assign job_rdy        = (state_q == ST_IDLE);
    assign sym_rdy        = (state_q == ST_STREAM) && lut_sa_hw_vld && (credit_used < CREDITS);
    assign sym_hs         = sym_val && sym_rdy;
    assign sa_lut_data_rd = sym_hs;
    assign sa_lut_seq_id  = seq_q;
    assign sa_lut_ret_ack = (state_q == ST_ACK);
    assign rdr_err        = err_q;
    assign rsp_push       = lut_sa_data_val && (outst_q != '0);
    assign out_val        = (dcnt_q != '0);
    assign out_pop        = out_val && out_rdy;
    assign sb_head        = smem[srd_q];
    assign d_head         = dmem[drd_q];
    assign out_cnt        = out_val ? sb_head[3:1] : 3'd0;
    assign out_last       = out_val && sb_head[0];

    always_comb begin
        sa_lut_data_addr0 = '0;
        sa_lut_data_addr1 = '0;
        sa_lut_data_addr2 = '0;
        sa_lut_data_addr3 = '0;
        if (sym_hs) begin
            sa_lut_data_addr0 = sym_addr[0 +: ADDR_W];
            if (cnt_eff >= 3'd2) sa_lut_data_addr1 = sym_addr[ADDR_W +: ADDR_W];
            if (cnt_eff >= 3'd3) sa_lut_data_addr2 = sym_addr[2*ADDR_W +: ADDR_W];
            if (cnt_eff >= 3'd4) sa_lut_data_addr3 = sym_addr[3*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < out_cnt) out_data[i*DATA_W +: DATA_W] = d_head[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        outst_d = outst_q;
        if (sym_hs && !rsp_push)      outst_d = outst_q + 1'b1;
        else if (!sym_hs && rsp_push) outst_d = outst_q - 1'b1;
        dcnt_d = dcnt_q;
        if (rsp_push && !out_pop)      dcnt_d = dcnt_q + 1'b1;
        else if (!rsp_push && out_pop) dcnt_d = dcnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            outst_q <= '0;
            dcnt_q  <= '0;
            dwr_q   <= '0;
            drd_q   <= '0;
            swr_q   <= '0;
            srd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            outst_q <= outst_d;
            dcnt_q  <= dcnt_d;
            if (lut_sa_data_val && outst_q == '0) err_q <= 1'b1;
            if (rsp_push) dwr_q <= (dwr_q == DP_LAST) ? '0 : dwr_q + 1'b1;
            if (sym_hs)   swr_q <= (swr_q == SP_LAST) ? '0 : swr_q + 1'b1;
            if (out_pop) begin
                drd_q <= (drd_q == DP_LAST) ? '0 : drd_q + 1'b1;
                srd_q <= (srd_q == SP_LAST) ? '0 : srd_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (job_val) begin
                        seq_q   <= job_seq_id;
                        state_q <= ST_WAIT_TBL;
                    end
                end
                ST_WAIT_TBL: if (lut_sa_hw_vld) state_q <= ST_STREAM;
                ST_STREAM:   if (sym_hs && sym_last) state_q <= ST_DRAIN;
                ST_DRAIN:    if (out_pop && out_last) state_q <= ST_ACK;
                ST_ACK:      state_q <= ST_IDLE;
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

    // Storage arrays carry data only; occupancy is tracked by the reset pointers above.
    always_ff @(posedge clk) begin
        if (rsp_push) dmem[dwr_q] <= {lut_sa_rd_data3, lut_sa_rd_data2, lut_sa_rd_data1, lut_sa_rd_data0};
        if (sym_hs)   smem[swr_q] <= {cnt_eff, sym_last};
    end

endmodule

// File: tb/tb_cr_huf_comp_sa_lut_rdr.sv
// Self-checking bench for cr_huf_comp_sa_lut_rdr: LUT responder plus an in-order beat scoreboard.
module tb_cr_huf_comp_sa_lut_rdr;
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 27;
    localparam int SEQID_W = 2;
    localparam int RD_LAT  = 2;
    localparam int FIFO_D  = 4;
    localparam int BOUND   = 200;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 job_val, job_rdy;
    logic [SEQID_W-1:0]   job_seq_id;
    logic                 sym_val, sym_rdy;
    logic [4*ADDR_W-1:0]  sym_addr;
    logic [2:0]           sym_cnt;
    logic                 sym_last;
    logic                 sa_lut_data_rd;
    logic [ADDR_W-1:0]    sa_lut_data_addr0, sa_lut_data_addr1, sa_lut_data_addr2, sa_lut_data_addr3;
    logic [SEQID_W-1:0]   sa_lut_seq_id;
    logic                 sa_lut_ret_ack;
    logic                 lut_sa_hw_vld, lut_sa_data_val;
    logic [DATA_W-1:0]    lut_sa_rd_data0, lut_sa_rd_data1, lut_sa_rd_data2, lut_sa_rd_data3;
    logic                 out_val, out_rdy;
    logic [4*DATA_W-1:0]  out_data;
    logic [2:0]           out_cnt;
    logic                 out_last;
    logic                 rdr_err;

    always #5 clk = ~clk;

    cr_huf_comp_sa_lut_rdr #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEQID_W(SEQID_W), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .job_val(job_val), .job_rdy(job_rdy), .job_seq_id(job_seq_id),
        .sym_val(sym_val), .sym_rdy(sym_rdy), .sym_addr(sym_addr), .sym_cnt(sym_cnt), .sym_last(sym_last),
        .sa_lut_data_rd(sa_lut_data_rd),
        .sa_lut_data_addr0(sa_lut_data_addr0), .sa_lut_data_addr1(sa_lut_data_addr1),
        .sa_lut_data_addr2(sa_lut_data_addr2), .sa_lut_data_addr3(sa_lut_data_addr3),
        .sa_lut_seq_id(sa_lut_seq_id), .sa_lut_ret_ack(sa_lut_ret_ack),
        .lut_sa_hw_vld(lut_sa_hw_vld), .lut_sa_data_val(lut_sa_data_val),
        .lut_sa_rd_data0(lut_sa_rd_data0), .lut_sa_rd_data1(lut_sa_rd_data1),
        .lut_sa_rd_data2(lut_sa_rd_data2), .lut_sa_rd_data3(lut_sa_rd_data3),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .out_cnt(out_cnt),
        .out_last(out_last), .rdr_err(rdr_err)
    );

    typedef struct {
        logic [4*DATA_W-1:0] data;
        logic [2:0]          cnt;
        logic                last;
    } beat_t;

    typedef struct {
        int                  due;
        logic [4*DATA_W-1:0] words;
    } rsp_t;

    beat_t exp_q[$];
    rsp_t  rsp_q[$];

    int n_chk = 0, n_pass = 0, cyc = 0;
    int n_rd = 0, pending = 0, n_ack = 0, sym_rdy_hi = 0;
    int last_pop_cyc = -100, ack_cyc = -1, job_hs_cyc = -1;
    int first_rd_cyc = -1, last_rd_cyc = -1, first_oval_cyc = -1;
    bit job_hs_seen = 0, beat_acc = 0, rand_mode = 0, spur_req = 0, seq_chk = 0;
    logic [SEQID_W-1:0] cur_seq = '0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    function automatic logic [DATA_W-1:0] lut_word(input logic [ADDR_W-1:0] a, input int lane);
        logic [31:0] h;
        h = {23'd0, a} * 32'd40503 + 32'(lane) * 32'h0123_4567 + 32'h00ab_cdef;
        return h[DATA_W-1:0] ^ {h[8:0], 18'd0};
    endfunction

    function automatic logic [4*ADDR_W-1:0] rnd_addr();
        logic [4*ADDR_W-1:0] a;
        for (int i = 0; i < 4; i++) a[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        return a;
    endfunction

    task automatic sample_cycle();
        logic [4*ADDR_W-1:0] dut_addr, exp_addr;
        beat_t b, got;
        rsp_t  r;
        int    ce;
        if (seq_chk) begin
            check_eq("seq_reg", sa_lut_seq_id, cur_seq);
            seq_chk = 0;
        end
        if (job_val && job_rdy) begin
            job_hs_seen = 1; job_hs_cyc = cyc; cur_seq = job_seq_id; seq_chk = 1;
            first_rd_cyc = -1; first_oval_cyc = -1;
        end
        if (sa_lut_data_rd) begin
            check_eq("rd_needs_val", sym_val, 1'b1);
            check_eq("credit", pending < FIFO_D, 1'b1);
            ce = (sym_cnt == 3'd0 || sym_cnt > 3'd4) ? 4 : int'(sym_cnt);
            exp_addr = '0;
            b.data   = '0;
            for (int i = 0; i < ce; i++) begin
                exp_addr[i*ADDR_W +: ADDR_W] = sym_addr[i*ADDR_W +: ADDR_W];
                b.data[i*DATA_W +: DATA_W]   = lut_word(sym_addr[i*ADDR_W +: ADDR_W], i);
            end
            dut_addr = {sa_lut_data_addr3, sa_lut_data_addr2, sa_lut_data_addr1, sa_lut_data_addr0};
            check_eq("rd_addr", dut_addr, exp_addr);
            b.cnt  = 3'(ce);
            b.last = sym_last;
            exp_q.push_back(b);
            r.due = cyc + RD_LAT;
            for (int i = 0; i < 4; i++) r.words[i*DATA_W +: DATA_W] = lut_word(dut_addr[i*ADDR_W +: ADDR_W], i);
            rsp_q.push_back(r);
            n_rd++; pending++; beat_acc = 1;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            last_rd_cyc = cyc;
        end
        if (sym_rdy) sym_rdy_hi++;
        if (out_val && first_oval_cyc < 0) first_oval_cyc = cyc;
        if (out_val && out_rdy) begin
            check_eq("pop_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                got = exp_q.pop_front();
                check_eq("out_data", out_data, got.data);
                check_eq("out_cnt", out_cnt, got.cnt);
                check_eq("out_last", out_last, got.last);
                if (got.last) last_pop_cyc = cyc;
            end
            pending--;
        end
        if (sa_lut_ret_ack) begin
            check_eq("ack_after_last", cyc, last_pop_cyc + 1);
            check_eq("ack_seq", sa_lut_seq_id, cur_seq);
            n_ack++; ack_cyc = cyc;
        end
    endtask

    task automatic drive_lut();
        rsp_t r;
        lut_sa_data_val = 1'b0;
        lut_sa_rd_data0 = DATA_W'($urandom);
        lut_sa_rd_data1 = DATA_W'($urandom);
        lut_sa_rd_data2 = DATA_W'($urandom);
        lut_sa_rd_data3 = DATA_W'($urandom);
        if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
            r = rsp_q.pop_front();
            lut_sa_data_val = 1'b1;
            lut_sa_rd_data0 = r.words[0 +: DATA_W];
            lut_sa_rd_data1 = r.words[DATA_W +: DATA_W];
            lut_sa_rd_data2 = r.words[2*DATA_W +: DATA_W];
            lut_sa_rd_data3 = r.words[3*DATA_W +: DATA_W];
        end else if (spur_req) begin
            lut_sa_data_val = 1'b1;
            spur_req = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample_cycle();
        @(posedge clk);
        #1;
        cyc++;
        drive_lut();
        if (rand_mode) begin
            lut_sa_hw_vld = ($urandom_range(0, 3) != 0);
            out_rdy       = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic do_job(input logic [SEQID_W-1:0] s);
        int n;
        n = 0;
        job_val = 1'b1; job_seq_id = s; job_hs_seen = 0;
        while (!job_hs_seen && n < BOUND) begin step(); n++; end
        check_eq("job_accept", job_hs_seen, 1'b1);
        job_val = 1'b0;
    endtask

    task automatic send_beat(input logic [4*ADDR_W-1:0] a, input logic [2:0] c, input logic l);
        int n;
        n = 0;
        sym_val = 1'b1; sym_addr = a; sym_cnt = c; sym_last = l; beat_acc = 0;
        while (!beat_acc && n < BOUND) begin step(); n++; end
        check_eq("beat_accept", beat_acc, 1'b1);
        sym_val = 1'b0;
    endtask

    task automatic wait_ack();
        int n, a0;
        n = 0; a0 = n_ack;
        while (n_ack == a0 && n < BOUND) begin step(); n++; end
        check_eq("ack_seen", n_ack != a0, 1'b1);
    endtask

    task automatic check_reset();
        check_eq("rst_job_rdy", job_rdy, 1'b1);
        check_eq("rst_sym_rdy", sym_rdy, 1'b0);
        check_eq("rst_data_rd", sa_lut_data_rd, 1'b0);
        check_eq("rst_addr", {sa_lut_data_addr3, sa_lut_data_addr2, sa_lut_data_addr1, sa_lut_data_addr0}, 36'd0);
        check_eq("rst_seq_id", sa_lut_seq_id, 2'd0);
        check_eq("rst_ret_ack", sa_lut_ret_ack, 1'b0);
        check_eq("rst_out_val", out_val, 1'b0);
        check_eq("rst_out_data", out_data, 108'd0);
        check_eq("rst_out_cnt", out_cnt, 3'd0);
        check_eq("rst_out_last", out_last, 1'b0);
        check_eq("rst_rdr_err", rdr_err, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [4*ADDR_W-1:0] a;
        logic [2:0] c;
        int r0, h0, k, nb, a0;
        rst_n = 1'b0; job_val = 1'b0; job_seq_id = '0;
        sym_val = 1'b0; sym_addr = '0; sym_cnt = 3'd1; sym_last = 1'b0;
        lut_sa_hw_vld = 1'b0; lut_sa_data_val = 1'b0; out_rdy = 1'b1;
        lut_sa_rd_data0 = '0; lut_sa_rd_data1 = '0; lut_sa_rd_data2 = '0; lut_sa_rd_data3 = '0;
        repeat (3) step();
        check_reset();
        rst_n = 1'b1;
        step();

        // single job: cnt 4,4,2
        lut_sa_hw_vld = 1'b1; out_rdy = 1'b1; r0 = n_rd;
        do_job(2'd1);
        send_beat(rnd_addr(), 3'd4, 1'b0);
        send_beat(rnd_addr(), 3'd4, 1'b0);
        send_beat(rnd_addr(), 3'd2, 1'b1);
        wait_ack();
        check_eq("t1_nrd", n_rd - r0, 3);
        check_eq("t1_rd_consec", last_rd_cyc - first_rd_cyc, 2);
        check_eq("t1_first_out", first_oval_cyc - first_rd_cyc, RD_LAT + 1);
        check_eq("t1_job_time", ack_cyc - job_hs_cyc, 1 + 3 + RD_LAT + 2);

        // table not ready for 10 cycles
        lut_sa_hw_vld = 1'b0;
        do_job(2'd2);
        a = rnd_addr();
        sym_val = 1'b1; sym_addr = a; sym_cnt = 3'd3; sym_last = 1'b1;
        r0 = n_rd; h0 = sym_rdy_hi;
        repeat (10) step();
        check_eq("t2_no_rd", n_rd - r0, 0);
        check_eq("t2_rdy_low", sym_rdy_hi - h0, 0);
        lut_sa_hw_vld = 1'b1; k = cyc;
        send_beat(a, 3'd3, 1'b1);
        check_eq("t2_stream_start", first_rd_cyc, k + 1);
        wait_ack();

        // backpressure: out_rdy low, 8 beats offered
        out_rdy = 1'b0;
        do_job(2'd3);
        r0 = n_rd;
        for (int i = 0; i < 4; i++) send_beat(rnd_addr(), 3'($urandom_range(0, 7)), 1'b0);
        a = rnd_addr(); c = 3'($urandom_range(0, 7));
        sym_val = 1'b1; sym_addr = a; sym_cnt = c; sym_last = 1'b0;
        repeat (12) step();
        check_eq("t3_nrd_stall", n_rd - r0, 4);
        check_eq("t3_rdy_low", sym_rdy, 1'b0);
        out_rdy = 1'b1;
        send_beat(a, c, 1'b0);
        send_beat(rnd_addr(), 3'($urandom_range(0, 7)), 1'b0);
        send_beat(rnd_addr(), 3'($urandom_range(0, 7)), 1'b0);
        send_beat(rnd_addr(), 3'($urandom_range(0, 7)), 1'b1);
        wait_ack();
        check_eq("t3_nrd", n_rd - r0, 8);

        // back-to-back jobs, seq 0 then 1
        do_job(2'd0);
        send_beat(rnd_addr(), 3'd4, 1'b0);
        send_beat(rnd_addr(), 3'd3, 1'b1);
        do_job(2'd1);
        check_eq("t4_next_job", job_hs_cyc, ack_cyc + 1);
        send_beat(rnd_addr(), 3'd1, 1'b1);
        wait_ack();

        // spurious response in IDLE
        spur_req = 1;
        step();
        step();
        check_eq("t5_err_set", rdr_err, 1'b1);
        check_eq("t5_no_oval", out_val, 1'b0);
        repeat (5) step();
        check_eq("t5_err_sticky", rdr_err, 1'b1);
        check_eq("t5_no_oval2", out_val, 1'b0);

        // randomized jobs
        rand_mode = 1;
        for (int j = 0; j < 6; j++) begin
            do_job(SEQID_W'($urandom));
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) send_beat(rnd_addr(), 3'($urandom_range(0, 7)), b == nb - 1);
            wait_ack();
        end
        rand_mode = 0; lut_sa_hw_vld = 1'b1; out_rdy = 1'b1;
        step();

        // reset with two reads outstanding
        a0 = n_ack;
        do_job(2'd3);
        send_beat(rnd_addr(), 3'd4, 1'b0);
        send_beat(rnd_addr(), 3'd2, 1'b0);
        sym_val = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset();
        repeat (3) step();
        exp_q.delete(); rsp_q.delete(); pending = 0;
        rst_n = 1'b1;
        repeat (8) step();
        check_eq("t7_no_ack", n_ack - a0, 0);
        check_eq("t7_err_clear", rdr_err, 1'b0);

        // recovery job after reset
        do_job(2'd2);
        send_beat(rnd_addr(), 3'd0, 1'b1);
        wait_ack();
        check_eq("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
